// File: rtl/dispatch_sequencer_if.sv
// rtl/dispatch_sequencer_if.sv - IFQ / issue-queue / redirect bundle for the dispatch sequencer
interface dispatch_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  empty;
    logic [1:0]            dec_queue;
    logic                  dec_jump;
    logic                  dec_jumpr;
    logic                  dec_branch;
    logic [DATA_WIDTH-1:0] jal_target;
    logic                  br_resolved;
    logic                  br_taken;
    logic [DATA_WIDTH-1:0] br_target;
    logic                  jalr_valid;
    logic [DATA_WIDTH-1:0] jalr_target;
    logic [3:0]            issue_done;
    logic                  Read_enable;
    logic [3:0]            dispatch_en;
    logic                  jump_branch_valid;
    logic [DATA_WIDTH-1:0] jump_branch_address;
    logic                  ifq_flush;
    logic [1:0]            state;

    // master: the sequencer itself; slave: the surrounding pipeline
    modport master (
        input  empty, dec_queue, dec_jump, dec_jumpr, dec_branch, jal_target,
               br_resolved, br_taken, br_target, jalr_valid, jalr_target, issue_done,
        output Read_enable, dispatch_en, jump_branch_valid, jump_branch_address,
               ifq_flush, state
    );

    modport slave (
        output empty, dec_queue, dec_jump, dec_jumpr, dec_branch, jal_target,
               br_resolved, br_taken, br_target, jalr_valid, jalr_target, issue_done,
        input  Read_enable, dispatch_en, jump_branch_valid, jump_branch_address,
               ifq_flush, state
    );
endinterface

// File: rtl/dispatch_sequencer.sv
// rtl/dispatch_sequencer.sv - in-order dispatch control FSM with issue-queue credits and redirect
module dispatch_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 3
) (
    input  logic               clk,
    input  logic               reset,
    dispatch_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        DISPATCH = 2'd0,
        WAIT_BR  = 2'd1,
        WAIT_JR  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(QUEUE_DEPTH);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  occ_q [4];
    logic [CNT_WIDTH-1:0]  occ_d [4];
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  redir_q, redir_d;
    logic                  fire;
    logic [3:0]            disp_en;

    // Credit check uses registered occupancy, so freed slots count from the next cycle
    assign fire = reset && (state_q == DISPATCH) && !bus.empty &&
                  (occ_q[bus.dec_queue] < DEPTH);
    assign disp_en = fire ? (4'b0001 << bus.dec_queue) : 4'b0000;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DISPATCH: begin
                if (fire) begin
                    if (bus.dec_jump) begin
                        state_d = REDIRECT;
                        addr_d  = bus.jal_target;
                    end else if (bus.dec_jumpr) begin
                        state_d = WAIT_JR;
                    end else if (bus.dec_branch) begin
                        state_d = WAIT_BR;
                    end
                end
            end
            WAIT_BR: begin
                if (bus.br_resolved) begin
                    if (bus.br_taken) begin
                        state_d = REDIRECT;
                        addr_d  = bus.br_target;
                    end else begin
                        state_d = DISPATCH;
                    end
                end
            end
            WAIT_JR: begin
                if (bus.jalr_valid) begin
                    state_d = REDIRECT;
                    addr_d  = bus.jalr_target;
                end
            end
            REDIRECT: state_d = DISPATCH;
            default:  state_d = DISPATCH;
        endcase
        redir_d = (state_d == REDIRECT);
    end

    always_comb begin
        for (int q = 0; q < 4; q++) begin
            occ_d[q] = occ_q[q];
            if (disp_en[q] && !bus.issue_done[q]) begin
                occ_d[q] = occ_q[q] + 1'b1;
            end else if (!disp_en[q] && bus.issue_done[q] && (occ_q[q] != '0)) begin
                occ_d[q] = occ_q[q] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DISPATCH;
            addr_q  <= '0;
            redir_q <= 1'b0;
            for (int q = 0; q < 4; q++) begin
                occ_q[q] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            redir_q <= redir_d;
            for (int q = 0; q < 4; q++) begin
                occ_q[q] <= occ_d[q];
            end
        end
    end

    assign bus.Read_enable         = fire;
    assign bus.dispatch_en         = disp_en;
    assign bus.jump_branch_valid   = redir_q;
    assign bus.ifq_flush           = redir_q;
    assign bus.jump_branch_address = addr_q;
    assign bus.state               = state_q;
endmodule

// File: tb/tb_dispatch_sequencer.sv
// tb/tb_dispatch_sequencer.sv - directed plus randomized checks against a behavioural dispatch model
module tb_dispatch_sequencer;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dispatch_sequencer_if #(.DATA_WIDTH(32)) bus ();

    dispatch_sequencer #(
        .DATA_WIDTH (32),
        .QUEUE_DEPTH(4),
        .CNT_WIDTH  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: credit count per queue, a mode number (0 dispatch, 1 branch wait,
    // 2 jalr wait, 3 redirect) and the last redirect target
    int          m_occ [4];
    int          m_mode;
    logic [31:0] m_addr;

    task automatic model_reset();
        for (int q = 0; q < 4; q++) m_occ[q] = 0;
        m_mode = 0;
        m_addr = 32'h0;
    endtask

    function automatic bit model_fire();
        return reset && (m_mode == 0) && !bus.empty && (m_occ[bus.dec_queue] < 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.empty       = 1'b1;
        bus.dec_queue   = 2'd0;
        bus.dec_jump    = 1'b0;
        bus.dec_jumpr   = 1'b0;
        bus.dec_branch  = 1'b0;
        bus.jal_target  = 32'h0;
        bus.br_resolved = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'h0;
        bus.jalr_valid  = 1'b0;
        bus.jalr_target = 32'h0;
        bus.issue_done  = 4'h0;
    endtask

    task automatic check_now();
        bit          f;
        logic [3:0]  de;
        #1;
        f  = model_fire();
        de = f ? (4'b0001 << bus.dec_queue) : 4'b0000;
        chk("read_enable", {31'b0, bus.Read_enable}, {31'b0, f});
        chk("dispatch_en", {28'b0, bus.dispatch_en}, {28'b0, de});
        chk("jb_valid", {31'b0, bus.jump_branch_valid}, (m_mode == 3) ? 32'd1 : 32'd0);
        chk("ifq_flush", {31'b0, bus.ifq_flush}, (m_mode == 3) ? 32'd1 : 32'd0);
        chk("jb_address", bus.jump_branch_address, m_addr);
        chk("state", {30'b0, bus.state}, m_mode);
    endtask

    task automatic adv();
        bit f;
        int nxt;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            f   = model_fire();
            nxt = m_mode;
            case (m_mode)
                0: if (f) begin
                    if (bus.dec_jump) begin nxt = 3; m_addr = bus.jal_target; end
                    else if (bus.dec_jumpr) nxt = 2;
                    else if (bus.dec_branch) nxt = 1;
                end
                1: if (bus.br_resolved) begin
                    if (bus.br_taken) begin nxt = 3; m_addr = bus.br_target; end
                    else nxt = 0;
                end
                2: if (bus.jalr_valid) begin nxt = 3; m_addr = bus.jalr_target; end
                default: nxt = 0;
            endcase
            m_mode = nxt;
            for (int q = 0; q < 4; q++) begin
                m_occ[q] += ((f && bus.dec_queue == q) ? 1 : 0) - (bus.issue_done[q] ? 1 : 0);
                if (m_occ[q] < 0) m_occ[q] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.issue_done = 4'hF;
            check_now();
            adv();
        end
        idle();
    endtask

    task automatic plain(input logic [1:0] q);
        idle();
        bus.empty     = 1'b0;
        bus.dec_queue = q;
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_now();
        chk("reset_re", {31'b0, bus.Read_enable}, 32'd0);
        chk("reset_state", {30'b0, bus.state}, 32'd0);
        reset = 1'b1;

        // Credit exhaustion on the int queue, then one freed entry
        for (int i = 0; i < 4; i++) begin
            plain(2'd0);
            check_now();
            chk("int_fill", {28'b0, bus.dispatch_en}, 32'h1);
            adv();
        end
        plain(2'd0);
        bus.issue_done = 4'b0001;
        check_now();
        chk("int_blocked", {31'b0, bus.Read_enable}, 32'd0);
        adv();
        plain(2'd0);
        check_now();
        chk("int_credit_back", {28'b0, bus.dispatch_en}, 32'h1);
        adv();
        drain();

        // JAL
        plain(2'd0);
        bus.dec_jump   = 1'b1;
        bus.jal_target = 32'h0000_0100;
        check_now();
        chk("jal_pop", {31'b0, bus.Read_enable}, 32'd1);
        adv();
        plain(2'd0);
        check_now();
        chk("jal_valid", {31'b0, bus.jump_branch_valid}, 32'd1);
        chk("jal_flush", {31'b0, bus.ifq_flush}, 32'd1);
        chk("jal_addr", bus.jump_branch_address, 32'h100);
        chk("jal_no_disp", {31'b0, bus.Read_enable}, 32'd0);
        adv();
        plain(2'd0);
        check_now();
        chk("jal_resume", {31'b0, bus.Read_enable}, 32'd1);
        chk("jal_valid_drop", {31'b0, bus.jump_branch_valid}, 32'd0);
        adv();
        drain();

        // Not-taken branch
        plain(2'd0);
        bus.dec_branch = 1'b1;
        check_now();
        adv();
        for (int i = 0; i < 3; i++) begin
            plain(2'd1);
            check_now();
            chk("br_wait_stall", {31'b0, bus.Read_enable}, 32'd0);
            adv();
        end
        plain(2'd1);
        bus.br_resolved = 1'b1;
        bus.br_target   = 32'hDEAD_0000;
        check_now();
        adv();
        plain(2'd1);
        check_now();
        chk("br_nt_state", {30'b0, bus.state}, 32'd0);
        chk("br_nt_noredir", {31'b0, bus.jump_branch_valid}, 32'd0);
        chk("br_nt_resume", {31'b0, bus.Read_enable}, 32'd1);
        adv();

        // Taken branch
        plain(2'd0);
        bus.dec_branch = 1'b1;
        check_now();
        adv();
        idle();
        bus.br_resolved = 1'b1;
        bus.br_taken    = 1'b1;
        bus.br_target   = 32'h0000_0040;
        check_now();
        adv();
        idle();
        check_now();
        chk("br_t_valid", {31'b0, bus.jump_branch_valid}, 32'd1);
        chk("br_t_addr", bus.jump_branch_address, 32'h40);
        adv();
        check_now();
        chk("br_t_oneshot", {31'b0, bus.ifq_flush}, 32'd0);
        chk("br_t_addr_hold", bus.jump_branch_address, 32'h40);
        adv();
        drain();

        // JALR with a stray branch resolution while waiting
        plain(2'd0);
        bus.dec_jumpr  = 1'b1;
        bus.dec_branch = 1'b1;
        check_now();
        adv();
        idle();
        bus.br_resolved = 1'b1;
        bus.br_taken    = 1'b1;
        bus.br_target   = 32'h0000_0999;
        check_now();
        adv();
        idle();
        check_now();
        chk("jr_ignore_br", {30'b0, bus.state}, 32'd2);
        bus.jalr_valid  = 1'b1;
        bus.jalr_target = 32'h0000_0200;
        adv();
        idle();
        check_now();
        chk("jr_addr", bus.jump_branch_address, 32'h200);
        chk("jr_valid", {31'b0, bus.jump_branch_valid}, 32'd1);
        adv();

        // Mul queue: simultaneous dispatch and free keeps the count
        for (int i = 0; i < 3; i++) begin
            plain(2'd1);
            check_now();
            adv();
        end
        plain(2'd1);
        bus.issue_done = 4'b0010;
        check_now();
        adv();
        plain(2'd1);
        check_now();
        chk("mul_4th", {28'b0, bus.dispatch_en}, 32'h2);
        adv();
        plain(2'd1);
        bus.issue_done = 4'b0010;
        check_now();
        chk("mul_full", {31'b0, bus.Read_enable}, 32'd0);
        adv();
        drain();

        // Asynchronous reset while waiting on a branch
        plain(2'd0);
        bus.dec_branch = 1'b1;
        bus.jal_target = 32'h0000_0123;
        check_now();
        adv();
        idle();
        check_now();
        chk("pre_rst_state", {30'b0, bus.state}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", {30'b0, bus.state}, 32'd0);
        chk("arst_valid", {31'b0, bus.jump_branch_valid}, 32'd0);
        chk("arst_flush", {31'b0, bus.ifq_flush}, 32'd0);
        chk("arst_addr", bus.jump_branch_address, 32'd0);
        chk("arst_re", {31'b0, bus.Read_enable}, 32'd0);
        model_reset();
        adv();
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            idle();
            bus.empty     = ($urandom_range(0, 3) == 0);
            bus.dec_queue = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                bus.dec_queue  = 2'd0;
                bus.dec_jump   = (r == 0) || (r == 3);
                bus.dec_jumpr  = (r == 1) || (r == 3);
                bus.dec_branch = (r == 2) || (r == 3);
            end
            bus.jal_target  = $urandom;
            bus.br_resolved = ($urandom_range(0, 2) == 0);
            bus.br_taken    = $urandom_range(0, 1) == 1;
            bus.br_target   = $urandom;
            bus.jalr_valid  = ($urandom_range(0, 2) == 0);
            bus.jalr_target = $urandom;
            bus.issue_done  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            check_now();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
